// File: rtl/spi_rx_stream_pkg.sv
// Shared SPI mode encodings and the sample-edge selection helper for spi_rx_stream.
package spi_rx_stream_pkg;

  localparam logic CPOL_IDLE_LOW  = 1'b0;
  localparam logic CPOL_IDLE_HIGH = 1'b1;
  localparam logic CPHA_LEADING   = 1'b0;
  localparam logic CPHA_TRAILING  = 1'b1;

  // The leading edge moves SCLK away from its idle level; the trailing edge returns it.
  function automatic logic sample_edge(input logic cpol, input logic cpha,
                                       input logic rise, input logic fall);
    logic leading;
    logic trailing;
    leading  = (cpol == CPOL_IDLE_HIGH) ? fall : rise;
    trailing = (cpol == CPOL_IDLE_HIGH) ? rise : fall;
    return (cpha == CPHA_TRAILING) ? trailing : leading;
  endfunction

endpackage

// File: rtl/spi_rx_stream_if.sv
// Valid/ready word stream carried from the SPI receiver to its consumer.
interface spi_rx_stream_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/spi_rx_stream_sync_fifo.sv
// Single-clock WIDTH x DEPTH FIFO with push/pop, full/empty flags and occupancy.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: storage carries no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o    = count_q;

endmodule

// File: rtl/spi_rx_stream.sv
// Oversampling SPI slave receiver feeding a valid/ready word FIFO.
// Optional frame_err detection is built when SPI_RX_STREAM_FRAME_ERR_EN is defined.
module spi_rx_stream
  import spi_rx_stream_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sclk_i,
  input  logic                   cs_n_i,
  input  logic                   mosi_i,
  spi_rx_stream_if.master        m_if,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   busy_o,
  output logic                   overrun_o,
  output logic                   frame_err_o
);
  localparam int   CW        = $clog2(WIDTH);
  localparam logic IDLE_SCLK = (CPOL != 0);

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise, sample;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= {SYNC_STAGES{IDLE_SCLK}};
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= IDLE_SCLK;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  // An SCLK edge landing on the same cycle as select assertion belongs to no frame.
  assign sample    = ~cs_s & ~cs_fall & sample_edge(IDLE_SCLK, CPHA != 0, sclk_rise, sclk_fall);

  logic [WIDTH-1:0] shift_q, shift_d, shift_in;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             push_q, push_d;
  logic [WIDTH-1:0] push_data_q, push_data_d;
  logic             overrun_q, overrun_d;
  logic             fifo_full, fifo_empty;

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign shift_in = {shift_q[WIDTH-2:0], mosi_s};
    end else begin : g_lsb_first
      assign shift_in = {mosi_s, shift_q[WIDTH-1:1]};
    end
  endgenerate

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    if (cs_fall || cs_rise) begin
      shift_d   = '0;
      bit_cnt_d = '0;
    end else if (sample) begin
      if (bit_cnt_q == CW'(WIDTH - 1)) begin
        push_d      = 1'b1;
        push_data_d = shift_in;
        shift_d     = '0;
        bit_cnt_d   = '0;
      end else begin
        shift_d   = shift_in;
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
    end
  end

  assign overrun_d = push_q & fifo_full & ~(m_if.valid & m_if.ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef SPI_RX_STREAM_FRAME_ERR_EN
  logic frame_err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_err_q <= 1'b0;
    else     frame_err_q <= cs_rise & (bit_cnt_q != '0);
  end
  assign frame_err_o = frame_err_q;
`else
  assign frame_err_o = 1'b0;
`endif

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_q),
    .push_data_i (push_data_q),
    .pop_i       (m_if.ready),
    .pop_data_o  (m_if.data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (level_o)
  );

  assign m_if.valid = ~fifo_empty;
  assign busy_o     = ~cs_s;
  assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_spi_rx_stream.sv
// Bench for spi_rx_stream: eight instances cover every CPOL/CPHA/bit-order combination.
module tb_spi_rx_stream;
  localparam int W    = 8;
  localparam int D    = 4;
  localparam int SS   = 2;
  localparam int HALF = 4;
  localparam int NI   = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         sclk_a [NI];
  logic         cs_a   [NI];
  logic         mosi_a [NI];
  logic         ready_a[NI];
  logic [W-1:0] data_a [NI];
  logic         valid_a[NI];
  logic [2:0]   level_a[NI];
  logic         busy_a [NI];
  logic         ovr_a  [NI];
  logic         ferr_a [NI];

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      spi_rx_stream_if #(.WIDTH(W)) sif ();
      assign sif.ready  = ready_a[g];
      assign data_a[g]  = sif.data;
      assign valid_a[g] = sif.valid;
      spi_rx_stream #(
        .WIDTH(W), .DEPTH(D), .CPOL(g % 2), .CPHA((g / 2) % 2),
        .MSB_FIRST((g < 4) ? 1 : 0), .SYNC_STAGES(SS)
      ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .sclk_i      (sclk_a[g]),
        .cs_n_i      (cs_a[g]),
        .mosi_i      (mosi_a[g]),
        .m_if        (sif),
        .level_o     (level_a[g]),
        .busy_o      (busy_a[g]),
        .overrun_o   (ovr_a[g]),
        .frame_err_o (ferr_a[g])
      );
    end
  endgenerate

  int n_tests = 0;
  int n_fail  = 0;
  int ovr_seen = 0;
  int ferr_seen = 0;
  logic [W-1:0] model_q[$];

  always @(negedge clk) begin
    if (ovr_a[0] === 1'b1) ovr_seen++;
    if (ferr_a[0] === 1'b1) ferr_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic cpol_of(input int k); return logic'(k % 2); endfunction
  function automatic logic cpha_of(input int k); return logic'((k / 2) % 2); endfunction

  // Words go out on the wire w[W-1] first; the receiver's bit order decides where it lands.
  function automatic logic [W-1:0] expect_word(input int k, input logic [W-1:0] w);
    logic [W-1:0] r;
    if (k < 4) return w;
    for (int i = 0; i < W; i++) r[i] = w[W-1-i];
    return r;
  endfunction

  // Reference FIFO: a full queue drops the arriving word.
  task automatic model_push(input int k, input logic [W-1:0] w);
    if (model_q.size() < D) model_q.push_back(expect_word(k, w));
  endtask

  task automatic wait_half();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_bit(input int k, input logic b);
    if (cpha_of(k) == 1'b0) begin
      mosi_a[k] = b;
      wait_half();
      sclk_a[k] = ~cpol_of(k);
      wait_half();
      sclk_a[k] = cpol_of(k);
    end else begin
      sclk_a[k] = ~cpol_of(k);
      mosi_a[k] = b;
      wait_half();
      sclk_a[k] = cpol_of(k);
      wait_half();
    end
  endtask

  task automatic send_bits(input int k, input logic [W-1:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) spi_bit(k, w[W-1-i]);
  endtask

  task automatic frame_begin(input int k);
    cs_a[k] = 1'b0;
    wait_half();
  endtask

  task automatic frame_end(input int k);
    wait_half();
    cs_a[k] = 1'b1;
    wait_half();
    wait_half();
  endtask

  task automatic pop_check(input int k, input string tag);
    logic [W-1:0] exp;
    int t;
    exp = model_q.pop_front();
    t = 0;
    while (valid_a[k] !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check({tag, "_timeout"}, 32'd0, 32'd1);
    else          check(tag, data_a[k], exp);
    ready_a[k] = 1'b1;
    @(negedge clk);
    ready_a[k] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] w, w5;
    int lat, base;

    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      sclk_a[k] = cpol_of(k); cs_a[k] = 1'b1; mosi_a[k] = 1'b0; ready_a[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_valid", valid_a[0], 0);
    check("rst_level", level_a[0], 0);
    check("rst_busy", busy_a[0], 0);
    check("rst_overrun", ovr_a[0], 0);
    check("rst_frame_err", ferr_a[0], 0);
    check("rst_data", data_a[0], 0);

    // Mode 0, 0xA5, with the final-bit-to-valid latency measured.
    w = 8'hA5;
    frame_begin(0);
    check("busy_in_frame", busy_a[0], 1);
    send_bits(0, w, W - 1);
    mosi_a[0] = w[0];
    wait_half();
    sclk_a[0] = 1'b1;
    lat = 0;
    while (valid_a[0] !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("a5_latency", lat, SS + 2);
    wait_half();
    sclk_a[0] = 1'b0;
    frame_end(0);
    model_push(0, w);
    check("a5_level", level_a[0], 1);
    pop_check(0, "a5_data");
    check("a5_level_after_pop", level_a[0], 0);

    // Every mode and bit order: 0x3C followed by a random word in one frame.
    for (int k = 0; k < NI; k++) begin
      w = W'($urandom);
      frame_begin(k);
      send_bits(k, 8'h3C, W);
      send_bits(k, w, W);
      frame_end(k);
      model_push(k, 8'h3C);
      model_push(k, w);
      check($sformatf("mode%0d_level", k), level_a[k], 2);
      pop_check(k, $sformatf("mode%0d_3c", k));
      pop_check(k, $sformatf("mode%0d_rand", k));
    end

    // Five words into a four-deep FIFO with no consumer.
    base = ovr_seen;
    frame_begin(0);
    for (int i = 0; i < 5; i++) begin
      w = W'($urandom);
      send_bits(0, w, W);
      model_push(0, w);
    end
    frame_end(0);
    check("ovr_pulses", ovr_seen - base, 1);
    check("ovr_level", level_a[0], D);
    for (int i = 0; i < D; i++) pop_check(0, $sformatf("ovr_word%0d", i));

    // Full FIFO with a pop on the very cycle the fifth word is pushed.
    base = ovr_seen;
    frame_begin(0);
    for (int i = 0; i < D; i++) begin
      w = W'($urandom);
      send_bits(0, w, W);
      model_push(0, w);
    end
    w5 = W'($urandom);
    send_bits(0, w5, W - 1);
    mosi_a[0] = w5[0];
    wait_half();
    sclk_a[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("fullpop_level_before", level_a[0], D);
    check("fullpop_head", data_a[0], model_q[0]);
    ready_a[0] = 1'b1;
    @(negedge clk);
    ready_a[0] = 1'b0;
    void'(model_q.pop_front());
    model_push(0, w5);
    sclk_a[0] = 1'b0;
    frame_end(0);
    check("fullpop_no_overrun", ovr_seen - base, 0);
    check("fullpop_level", level_a[0], D);
    for (int i = 0; i < D; i++) pop_check(0, $sformatf("fullpop_word%0d", i));

    // Select released after three bits, then a clean 0x81.
    base = ferr_seen;
    frame_begin(0);
    send_bits(0, W'($urandom), 3);
    frame_end(0);
`ifdef SPI_RX_STREAM_FRAME_ERR_EN
    check("partial_frame_err", ferr_seen - base, 1);
`else
    check("partial_frame_err", ferr_seen - base, 0);
`endif
    check("partial_level", level_a[0], 0);
    frame_begin(0);
    send_bits(0, 8'h81, W);
    frame_end(0);
    model_push(0, 8'h81);
    pop_check(0, "after_partial_81");

    // Reset in the middle of a word with two words queued.
    frame_begin(0);
    for (int i = 0; i < 2; i++) begin
      w = W'($urandom);
      send_bits(0, w, W);
      model_push(0, w);
    end
    send_bits(0, W'($urandom), 3);
    check("prerst_level", level_a[0], 2);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_level", level_a[0], 0);
    check("midrst_valid", valid_a[0], 0);
    model_q.delete();
    @(negedge clk);
    rst = 1'b0;
    cs_a[0] = 1'b1;
    wait_half();
    w = W'($urandom);
    frame_begin(0);
    send_bits(0, w, W);
    frame_end(0);
    model_push(0, w);
    check("postrst_level", level_a[0], 1);
    pop_check(0, "postrst_word");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
